// File: rtl/uart_tx.sv
// UART transmitter: one word per valid/ready handshake, serialized as
// start, LSB-first data, optional parity and 1 or 2 stop bits at i_clk/P_DIV baud.
module uart_tx #(
    parameter int unsigned P_SYSTEM_CLK      = 50_000_000,
    parameter int unsigned P_UART_BAUDRATE   = 9600,
    parameter int unsigned P_UART_DATA_WIDTH = 8,
    parameter int unsigned P_UART_STOP_WIDTH = 1,
    parameter int unsigned P_UART_CHECK      = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [P_UART_DATA_WIDTH-1:0] i_user_tx_data,
    input  logic                         i_user_tx_valid,
    output logic                         o_user_tx_ready,
    output logic                         o_user_tx_busy,
    output logic                         o_uart_tx
);

    localparam int unsigned DIV    = P_SYSTEM_CLK / P_UART_BAUDRATE;
    localparam int unsigned BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W  = 4;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(P_UART_DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(P_UART_STOP_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                       state, state_n;
    logic [BAUD_W-1:0]            baud_cnt, baud_n;
    logic [BIT_W-1:0]             bit_cnt, bit_n;
    logic [P_UART_DATA_WIDTH-1:0] shift_reg, shift_n;
    logic                         parity_bit, parity_n;
    logic                         tx_n, ready_n, busy_n;
    logic                         bit_done;

    // Next-state logic; line and handshake outputs are derived from the next
    // state so they can be registered without an extra cycle of latency.
    always_comb begin
        state_n  = state;
        baud_n   = baud_cnt;
        bit_n    = bit_cnt;
        shift_n  = shift_reg;
        parity_n = parity_bit;
        tx_n     = 1'b1;
        ready_n  = 1'b0;
        busy_n   = 1'b1;
        bit_done = (baud_cnt == BAUD_LAST);

        if (state != S_IDLE) begin
            baud_n = bit_done ? '0 : baud_cnt + BAUD_W'(1);
        end

        case (state)
            S_IDLE: begin
                if (i_user_tx_valid) begin
                    state_n  = S_START;
                    shift_n  = i_user_tx_data;
                    parity_n = (P_UART_CHECK == 1) ? ~^i_user_tx_data : ^i_user_tx_data;
                    baud_n   = '0;
                    bit_n    = '0;
                end
            end
            S_START: begin
                if (bit_done) state_n = S_DATA;
            end
            S_DATA: begin
                if (bit_done) begin
                    shift_n = shift_reg >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_n   = '0;
                        state_n = (P_UART_CHECK > 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_n = bit_cnt + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) state_n = S_STOP;
            end
            S_STOP: begin
                if (bit_done) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_n   = '0;
                        state_n = S_IDLE;
                    end else begin
                        bit_n = bit_cnt + BIT_W'(1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shift_n[0];
            S_PARITY: tx_n = parity_n;
            default:  tx_n = 1'b1;
        endcase

        ready_n = (state_n == S_IDLE);
        busy_n  = ~ready_n;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= S_IDLE;
            baud_cnt        <= '0;
            bit_cnt         <= '0;
            shift_reg       <= '0;
            parity_bit      <= 1'b0;
            o_uart_tx       <= 1'b1;
            o_user_tx_ready <= 1'b1;
            o_user_tx_busy  <= 1'b0;
        end else begin
            state           <= state_n;
            baud_cnt        <= baud_n;
            bit_cnt         <= bit_n;
            shift_reg       <= shift_n;
            parity_bit      <= parity_n;
            o_uart_tx       <= tx_n;
            o_user_tx_ready <= ready_n;
            o_user_tx_busy  <= busy_n;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four configurations (8N1 div4, odd parity,
// even parity with 2 stop bits, div1) checked against hand-built frames.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] data [4];
    logic [3:0] valid;
    logic [3:0] tx, ready, busy;

    int errors = 0;
    int checks = 0;

    uart_tx #(.P_SYSTEM_CLK(4), .P_UART_BAUDRATE(1), .P_UART_DATA_WIDTH(8),
              .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0)) dut_n (
        .i_clk(clk), .i_rst(rst), .i_user_tx_data(data[0]), .i_user_tx_valid(valid[0]),
        .o_user_tx_ready(ready[0]), .o_user_tx_busy(busy[0]), .o_uart_tx(tx[0]));

    uart_tx #(.P_SYSTEM_CLK(4), .P_UART_BAUDRATE(1), .P_UART_DATA_WIDTH(8),
              .P_UART_STOP_WIDTH(1), .P_UART_CHECK(1)) dut_o (
        .i_clk(clk), .i_rst(rst), .i_user_tx_data(data[1]), .i_user_tx_valid(valid[1]),
        .o_user_tx_ready(ready[1]), .o_user_tx_busy(busy[1]), .o_uart_tx(tx[1]));

    uart_tx #(.P_SYSTEM_CLK(4), .P_UART_BAUDRATE(1), .P_UART_DATA_WIDTH(8),
              .P_UART_STOP_WIDTH(2), .P_UART_CHECK(2)) dut_e (
        .i_clk(clk), .i_rst(rst), .i_user_tx_data(data[2]), .i_user_tx_valid(valid[2]),
        .o_user_tx_ready(ready[2]), .o_user_tx_busy(busy[2]), .o_uart_tx(tx[2]));

    uart_tx #(.P_SYSTEM_CLK(1), .P_UART_BAUDRATE(1), .P_UART_DATA_WIDTH(8),
              .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0)) dut_1 (
        .i_clk(clk), .i_rst(rst), .i_user_tx_data(data[3]), .i_user_tx_valid(valid[3]),
        .o_user_tx_ready(ready[3]), .o_user_tx_busy(busy[3]), .o_uart_tx(tx[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake one word into DUT d and check every line sample against exp
    // (bit 0 of exp is the start bit); optional one-cycle valid glitch mid-frame.
    task automatic run_frame(input int d, input logic [7:0] w, input int div, input int nb,
                             input logic [11:0] exp, input string nm, input int glitch_at);
        int   waited;
        logic bad, rdy_bad, got;
        @(negedge clk);
        waited = 0;
        while (ready[d] !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait: ready=%b required 1", nm, ready[d]);
        end
        data[d]  = w;
        valid[d] = 1'b1;
        @(negedge clk);
        valid[d] = 1'b0;
        checks++;
        if ({tx[d], ready[d], busy[d]} !== 3'b001) begin
            errors++;
            $display("FAIL %s start_latency: tx/ready/busy=%b required 001",
                     nm, {tx[d], ready[d], busy[d]});
        end
        rdy_bad = 1'b0;
        for (int b = 0; b < nb; b++) begin
            bad = 1'b0;
            got = exp[b];
            for (int c = 0; c < div; c++) begin
                if (b * div + c == glitch_at) begin
                    valid[d] = 1'b1;
                    data[d]  = ~w;
                end else if (b * div + c == glitch_at + 1) begin
                    valid[d] = 1'b0;
                end
                if (tx[d] !== exp[b]) begin
                    bad = 1'b1;
                    got = tx[d];
                end
                if (ready[d] !== 1'b0 || busy[d] !== 1'b1) rdy_bad = 1'b1;
                @(negedge clk);
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s line_bit%0d: tx=%b required %b", nm, b, got, exp[b]);
            end
        end
        valid[d] = 1'b0;
        checks++;
        if (rdy_bad) begin
            errors++;
            $display("FAIL %s busy_window: ready/busy left 0/1 during the %0d-clock frame", nm, nb * div);
        end
        checks++;
        if ({tx[d], ready[d], busy[d]} !== 3'b110) begin
            errors++;
            $display("FAIL %s frame_end: tx/ready/busy=%b required 110", nm, {tx[d], ready[d], busy[d]});
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        valid = '0;
        for (int i = 0; i < 4; i++) data[i] = 8'h00;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({tx[i], ready[i], busy[i]} !== 3'b110) begin
                errors++;
                $display("FAIL reset_state dut%0d: tx/ready/busy=%b required 110",
                         i, {tx[i], ready[i], busy[i]});
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_frame(0, 8'hA5, 4, 10, 12'({1'b1, 8'hA5, 1'b0}), "basic_a5", -1);
        run_frame(3, 8'hC3, 1, 10, 12'({1'b1, 8'hC3, 1'b0}), "div1_c3", -1);
    endtask

    task automatic test_parity();
        run_frame(1, 8'hA5, 4, 11, 12'({1'b1, 1'b1, 8'hA5, 1'b0}), "odd_a5", -1);
        run_frame(1, 8'h01, 4, 11, 12'({1'b1, 1'b0, 8'h01, 1'b0}), "odd_01", -1);
        run_frame(2, 8'h00, 4, 12, 12'({2'b11, 1'b0, 8'h00, 1'b0}), "even2s_00", -1);
    endtask

    task automatic test_back_to_back();
        logic       s [100];
        logic       drop;
        logic [7:0] w1, w2;
        int         start2, st2;
        @(negedge clk);
        data[0]  = 8'h55;
        valid[0] = 1'b1;
        @(negedge clk);
        data[0] = 8'hAA;
        drop    = 1'b0;
        for (int k = 0; k < 100; k++) begin
            s[k] = tx[0];
            if (drop) valid[0] = 1'b0;
            if (k > 0 && ready[0] === 1'b1) drop = 1'b1;
            @(negedge clk);
        end
        valid[0] = 1'b0;
        start2 = -1;
        for (int m = 40; m < 100; m++) begin
            if (start2 < 0 && s[m] === 1'b0 && s[m-1] === 1'b1) start2 = m;
        end
        st2 = (start2 > 0 && start2 < 60) ? start2 : 41;
        for (int b = 0; b < 8; b++) begin
            w1[b] = s[4 * (b + 1) + 2];
            w2[b] = s[st2 + 4 * (b + 1) + 2];
        end
        checks++;
        if (s[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_start1: tx=%b required 0", s[0]);
        end
        checks++;
        if (start2 != 41) begin
            errors++;
            $display("FAIL b2b_spacing: start edges %0d clocks apart, required 41", start2);
        end
        checks++;
        if (w1 !== 8'h55 || s[38] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_word1: got %h stop=%b required 55 stop=1", w1, s[38]);
        end
        checks++;
        if (w2 !== 8'hAA || s[st2 + 38] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_word2: got %h stop=%b required aa stop=1", w2, s[st2 + 38]);
        end
    endtask

    task automatic test_busy_ignore();
        logic seen;
        run_frame(0, 8'h96, 4, 10, 12'({1'b1, 8'h96, 1'b0}), "busy_glitch", 12);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (tx[0] !== 1'b1 || ready[0] !== 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL busy_no_second_frame: line left idle after frame, required idle for 50 clocks");
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        data[0]  = 8'h00;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (17) @(negedge clk);
        checks++;
        if (tx[0] !== 1'b0 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_inflight: tx/busy=%b required 01", {tx[0], busy[0]});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({tx[0], ready[0], busy[0]} !== 3'b110) begin
            errors++;
            $display("FAIL rstmid_immediate: tx/ready/busy=%b required 110", {tx[0], ready[0], busy[0]});
        end
        @(negedge clk);
        rst = 1'b0;
        run_frame(0, 8'h3C, 4, 10, 12'({1'b1, 8'h3C, 1'b0}), "after_rst_3c", -1);
    endtask

    initial begin
        rst   = 1'b1;
        valid = '0;
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
